// File: rtl/conv2d_stream_requant.sv
// Streaming Conv2D layer engine: buffers one input feature map, then scans
// output positions (stride + zero padding), accumulates every tap for all
// output channels in parallel, requantises to int8 and emits one pixel per
// valid/ready handshake.
module conv2d_stream_requant #(
  parameter int F_IN_W      = 29,
  parameter int F_IN_H      = 13,
  parameter int F_IN_D      = 1,
  parameter int F_OUT_D     = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 2,
  parameter int PAD         = 0,
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 32,
  parameter int ADDR_W      = 12
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                feature_in_valid_i,
  input  logic [F_IN_D*DATA_W-1:0]            feature_in_data_i,
  input  logic [ADDR_W-1:0]                   feature_in_addr_i,
  output logic                                feature_in_ready_o,
  input  logic                                kernel_weights_valid_i,
  input  logic [F_OUT_D*F_IN_D*DATA_W-1:0]    kernel_weights_data_i,
  input  logic [ADDR_W-1:0]                   kernel_weights_addr_i,
  input  logic [F_OUT_D*ACC_W-1:0]            kernel_biases_data_i,
  input  logic [F_OUT_D*32-1:0]               kernel_dwscaling_m0_i,
  input  logic [F_OUT_D*4-1:0]                kernel_dwscaling_n_i,
  input  logic                                relu_en_i,
  output logic                                feature_out_valid_o,
  output logic [F_OUT_D*DATA_W-1:0]           feature_out_data_o,
  output logic [ADDR_W-1:0]                   feature_out_addr_o,
  input  logic                                feature_out_ready_i,
  output logic                                frame_done_o
);
  localparam int F_OUT_W = (F_IN_W + 2*PAD - KERNEL_SIZE) / STRIDE + 1;
  localparam int F_OUT_H = (F_IN_H + 2*PAD - KERNEL_SIZE) / STRIDE + 1;
  localparam int NPIX    = F_IN_W * F_IN_H;
  localparam int NTAP    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PIX_AW  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TAP_AW  = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] CI_LAST  = ADDR_W'(F_IN_D - 1);
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(KERNEL_SIZE - 1);
  localparam logic [ADDR_W-1:0] OX_LAST  = ADDR_W'(F_OUT_W - 1);
  localparam logic [ADDR_W-1:0] OY_LAST  = ADDR_W'(F_OUT_H - 1);
  localparam logic signed [65:0] QMAX = (66'sd1 <<< (DATA_W-1)) - 66'sd1;
  localparam logic signed [65:0] QMIN = -(66'sd1 <<< (DATA_W-1));

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_QUANT, S_OUT} state_e;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] ci_q, ci_d, kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic issue_q, issue_d;
  // tap pipeline: stage 1 holds the buffer read, stage 2 flags the last accumulate
  logic s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic s1_oob_q, s1_oob_d, s2_last_q, s2_last_d;
  logic [ADDR_W-1:0] s1_ci_q, s1_ci_d;
  logic [F_OUT_D-1:0][ACC_W-1:0]  acc_q, acc_d;
  logic [F_OUT_D-1:0][DATA_W-1:0] out_data_q, out_data_d, quant;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic out_vld_q, out_vld_d, done_q, done_d, in_rdy_q, in_rdy_d;

  logic [F_IN_D*DATA_W-1:0]         fmem [NPIX];
  logic [F_OUT_D*F_IN_D*DATA_W-1:0] wmem [NTAP];
  logic [F_IN_D*DATA_W-1:0]         rd_q;
  logic [F_OUT_D*F_IN_D*DATA_W-1:0] s1_w_q;

  logic fwr, wwr, oob, last_tap;
  logic [PIX_AW-1:0] pix_idx;
  logic [TAP_AW-1:0] tap_idx;
  int ix, iy;

  assign fwr = feature_in_valid_i && in_rdy_q &&
               ({1'b0, feature_in_addr_i} < (ADDR_W+1)'(NPIX));
  assign wwr = kernel_weights_valid_i && (state_q == S_LOAD) &&
               ({1'b0, kernel_weights_addr_i} < (ADDR_W+1)'(NTAP));
  assign last_tap = (ci_q == CI_LAST) && (kx_q == K_LAST) && (ky_q == K_LAST);

  // input coordinate of the current tap; padded positions read address 0 and are masked
  always_comb begin
    ix = int'(ox_q) * STRIDE + int'(kx_q) - PAD;
    iy = int'(oy_q) * STRIDE + int'(ky_q) - PAD;
    oob = (ix < 0) || (ix >= F_IN_W) || (iy < 0) || (iy >= F_IN_H);
    pix_idx = oob ? '0 : PIX_AW'(iy * F_IN_W + ix);
    tap_idx = TAP_AW'(int'(ky_q) * KERNEL_SIZE + int'(kx_q));
  end

  // feature/weight RAMs with registered read ports (contents survive reset)
  always_ff @(posedge clk_i) begin
    if (fwr) fmem[PIX_AW'(feature_in_addr_i)] <= feature_in_data_i;
    if (wwr) wmem[TAP_AW'(kernel_weights_addr_i)] <= kernel_weights_data_i;
    rd_q   <= fmem[pix_idx];
    s1_w_q <= wmem[tap_idx];
  end

  // multiply-accumulate of one tap for every output channel; bias seeds tap 0
  always_comb begin
    logic signed [DATA_W-1:0]   x, w;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           base;
    acc_d = acc_q;
    x = '0; w = '0; prod = '0; base = '0;
    if (s1_vld_q) begin
      for (int co = 0; co < F_OUT_D; co++) begin
        x    = rd_q[int'(s1_ci_q)*DATA_W +: DATA_W];
        w    = s1_w_q[(co*F_IN_D + int'(s1_ci_q))*DATA_W +: DATA_W];
        prod = x * w;
        base = s1_first_q ? kernel_biases_data_i[co*ACC_W +: ACC_W] : acc_q[co];
        acc_d[co] = base + (s1_oob_q ? '0 : ACC_W'(prod));
      end
    end
  end

  // requantise: Q0.32 multiply, round-half-up shift, saturate, optional ReLU
  always_comb begin
    logic signed [65:0] p, rr;
    logic [3:0] n;
    p = '0; rr = '0; n = '0;
    for (int co = 0; co < F_OUT_D; co++) begin
      n  = kernel_dwscaling_n_i[co*4 +: 4];
      p  = $signed({{(66-ACC_W){acc_q[co][ACC_W-1]}}, acc_q[co]}) *
           $signed({34'b0, kernel_dwscaling_m0_i[co*32 +: 32]});
      rr = (p + (66'sd1 <<< (31 + int'(n)))) >>> (32 + int'(n));
      if (rr > QMAX) rr = QMAX;
      else if (rr < QMIN) rr = QMIN;
      if (relu_en_i && rr < 0) rr = '0;
      quant[co] = DATA_W'(rr);
    end
  end

  // frame sequencing: load, per-pixel tap scan, quantise, output handshake
  always_comb begin
    state_d = state_q;
    ci_d = ci_q; kx_d = kx_q; ky_d = ky_q; ox_d = ox_q; oy_d = oy_q;
    issue_d = issue_q;
    s1_vld_d   = issue_q;
    s1_first_d = issue_q && (ci_q == '0) && (kx_q == '0) && (ky_q == '0);
    s1_last_d  = issue_q && last_tap;
    s1_oob_d   = oob;
    s1_ci_d    = ci_q;
    s2_last_d  = s1_vld_q && s1_last_q;
    out_data_d = out_data_q; out_addr_d = out_addr_q; out_vld_d = out_vld_q;
    done_d = 1'b0;
    case (state_q)
      S_LOAD: if (fwr && feature_in_addr_i == LAST_PIX) begin
        state_d = S_MAC; issue_d = 1'b1;
        ci_d = '0; kx_d = '0; ky_d = '0; ox_d = '0; oy_d = '0;
      end
      S_MAC: begin
        if (issue_q) begin
          if (ci_q == CI_LAST) begin
            ci_d = '0;
            if (kx_q == K_LAST) begin
              kx_d = '0;
              if (ky_q == K_LAST) begin ky_d = '0; issue_d = 1'b0; end
              else ky_d = ky_q + 1'b1;
            end else kx_d = kx_q + 1'b1;
          end else ci_d = ci_q + 1'b1;
        end
        if (s2_last_q) state_d = S_QUANT;
      end
      S_QUANT: begin
        out_data_d = quant;
        out_addr_d = ADDR_W'(int'(oy_q) * F_OUT_W + int'(ox_q));
        out_vld_d  = 1'b1;
        state_d    = S_OUT;
      end
      S_OUT: if (feature_out_ready_i) begin
        out_vld_d = 1'b0;
        if (ox_q == OX_LAST && oy_q == OY_LAST) begin
          done_d = 1'b1; state_d = S_LOAD;
        end else begin
          if (ox_q == OX_LAST) begin ox_d = '0; oy_d = oy_q + 1'b1; end
          else ox_d = ox_q + 1'b1;
          ci_d = '0; kx_d = '0; ky_d = '0;
          issue_d = 1'b1; state_d = S_MAC;
        end
      end
      default: state_d = S_LOAD;
    endcase
    in_rdy_d = (state_d == S_LOAD);
  end

  // state and control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_LOAD;
      ci_q <= '0; kx_q <= '0; ky_q <= '0; ox_q <= '0; oy_q <= '0;
      issue_q <= 1'b0;
      s1_vld_q <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
      s1_oob_q <= 1'b0; s1_ci_q <= '0; s2_last_q <= 1'b0;
      acc_q <= '0;
      out_data_q <= '0; out_addr_q <= '0; out_vld_q <= 1'b0;
      done_q <= 1'b0; in_rdy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ci_q <= ci_d; kx_q <= kx_d; ky_q <= ky_d; ox_q <= ox_d; oy_q <= oy_d;
      issue_q <= issue_d;
      s1_vld_q <= s1_vld_d; s1_first_q <= s1_first_d; s1_last_q <= s1_last_d;
      s1_oob_q <= s1_oob_d; s1_ci_q <= s1_ci_d; s2_last_q <= s2_last_d;
      acc_q <= acc_d;
      out_data_q <= out_data_d; out_addr_q <= out_addr_d; out_vld_q <= out_vld_d;
      done_q <= done_d; in_rdy_q <= in_rdy_d;
    end
  end

  assign feature_in_ready_o  = in_rdy_q;
  assign feature_out_valid_o = out_vld_q;
  assign feature_out_data_o  = out_data_q;
  assign feature_out_addr_o  = out_addr_q;
  assign frame_done_o        = done_q;
endmodule

// File: tb/tb_conv2d_stream_requant.sv
// Directed bench: a small 4x4 padded two-channel instance for value,
// backpressure and reset cases, plus a default-parameter instance for
// latency and raster order of the layer-1 shape.
module tb_conv2d_stream_requant;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
  endtask

  // small instance: 4x4x1 -> 4x4x2, K=3, STRIDE=1, PAD=1
  logic        s_fvld = 0, s_frdy, s_wvld = 0, s_relu = 0, s_vout, s_rdy_out = 1, s_done;
  logic [7:0]  s_fdata = 0;
  logic [11:0] s_faddr = 0, s_waddr = 0, s_aout;
  logic [15:0] s_wdata = 0, s_dout;
  logic [63:0] s_bias = 0, s_m0 = 0;
  logic [7:0]  s_n = 0;
  int          s_done_cnt = 0;

  conv2d_stream_requant #(.F_IN_W(4), .F_IN_H(4), .F_IN_D(1), .F_OUT_D(2),
    .KERNEL_SIZE(3), .STRIDE(1), .PAD(1)) u_small (
    .clk_i(clk), .rst_ni(rst_n),
    .feature_in_valid_i(s_fvld), .feature_in_data_i(s_fdata), .feature_in_addr_i(s_faddr),
    .feature_in_ready_o(s_frdy),
    .kernel_weights_valid_i(s_wvld), .kernel_weights_data_i(s_wdata),
    .kernel_weights_addr_i(s_waddr), .kernel_biases_data_i(s_bias),
    .kernel_dwscaling_m0_i(s_m0), .kernel_dwscaling_n_i(s_n), .relu_en_i(s_relu),
    .feature_out_valid_o(s_vout), .feature_out_data_o(s_dout), .feature_out_addr_o(s_aout),
    .feature_out_ready_i(s_rdy_out), .frame_done_o(s_done));

  // default instance: 29x13x1 -> 14x6x4
  logic         d_fvld = 0, d_frdy, d_wvld = 0, d_vout, d_rdy_out = 1, d_done;
  logic [7:0]   d_fdata = 0;
  logic [11:0]  d_faddr = 0, d_waddr = 0, d_aout;
  logic [31:0]  d_wdata = 0, d_dout;
  logic [127:0] d_bias = 0, d_m0 = 0;
  logic [15:0]  d_n = 0;
  int           d_done_cnt = 0;

  conv2d_stream_requant u_dflt (
    .clk_i(clk), .rst_ni(rst_n),
    .feature_in_valid_i(d_fvld), .feature_in_data_i(d_fdata), .feature_in_addr_i(d_faddr),
    .feature_in_ready_o(d_frdy),
    .kernel_weights_valid_i(d_wvld), .kernel_weights_data_i(d_wdata),
    .kernel_weights_addr_i(d_waddr), .kernel_biases_data_i(d_bias),
    .kernel_dwscaling_m0_i(d_m0), .kernel_dwscaling_n_i(d_n), .relu_en_i(1'b0),
    .feature_out_valid_o(d_vout), .feature_out_data_o(d_dout), .feature_out_addr_o(d_aout),
    .feature_out_ready_i(d_rdy_out), .frame_done_o(d_done));

  always @(posedge clk) begin
    if (s_done) s_done_cnt <= s_done_cnt + 1;
    if (d_done) d_done_cnt <= d_done_cnt + 1;
  end

  // 0 corner, 1 edge, 2 centre of the 4x4 output map
  function automatic int cls_of(input int k);
    bit ex, ey;
    ex = (k % 4 == 0) || (k % 4 == 3);
    ey = (k / 4 == 0) || (k / 4 == 3);
    return (ex && ey) ? 0 : ((ex || ey) ? 1 : 2);
  endfunction

  task automatic s_wr(input int a, input logic [7:0] d);
    @(negedge clk); s_fvld = 1; s_faddr = 12'(a); s_fdata = d;
  endtask

  // weights for all taps, then pixels in non-raster order; addr 16 would alias pixel 0
  task automatic load_s(input logic [7:0] pix, input logic [7:0] w0, input logic [7:0] w1);
    for (int t = 0; t < 9; t++) begin
      @(negedge clk); s_wvld = 1; s_waddr = 12'(t); s_wdata = {w1, w0};
    end
    @(negedge clk); s_wvld = 0;
    for (int a = 14; a >= 0; a--) s_wr(a, pix);
    s_wr(16, 8'd100);
    s_wr(15, pix);
    @(negedge clk); s_fvld = 0;
  endtask

  task automatic collect_s(input int e0[3], input int e1[3], input bit stall);
    int lat, d0, c;
    logic [15:0] dsav;
    d0 = s_done_cnt;
    for (int k = 0; k < 16; k++) begin
      lat = 0;
      while (!s_vout && lat < 100) begin lat++; @(negedge clk); end
      if (!s_vout) begin chk("out_valid_timeout", 0, 1); break; end
      if (k < 2) chk("latency", lat, 12);
      c = cls_of(k);
      chk("out_addr", int'(s_aout), k);
      chk("ch0", int'($signed(s_dout[7:0])), e0[c]);
      chk("ch1", int'($signed(s_dout[15:8])), e1[c]);
      if (stall && k == 3) begin
        dsav = s_dout;
        s_rdy_out = 0;
        s_fvld = 1; s_faddr = 12'd5; s_fdata = 8'd50;
        s_wvld = 1; s_waddr = 12'd4; s_wdata = 16'h0000;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_valid", int'(s_vout), 1);
          chk("stall_addr", int'(s_aout), 3);
          chk("stall_data", int'(s_dout), int'(dsav));
        end
        chk("in_ready_out", int'(s_frdy), 0);
        s_fvld = 0; s_wvld = 0; s_rdy_out = 1;
      end
      @(negedge clk);
      if (k == 15) begin
        chk("frame_done", int'(s_done), 1);
        chk("in_ready_load", int'(s_frdy), 1);
      end
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", s_done_cnt - d0, 1);
  endtask

  initial begin
    int lat;
    s_m0 = {2{32'h8000_0000}};
    #12;
    chk("rst_in_ready", int'(s_frdy), 1);
    chk("rst_valid", int'(s_vout), 0);
    chk("rst_data", int'(s_dout), 0);
    chk("rst_addr", int'(s_aout), 0);
    chk("rst_done", int'(s_done), 0);
    @(negedge clk); rst_n = 1;

    // ones through +1 / -1 kernels, with backpressure on output 3
    load_s(8'd1, 8'd1, 8'hFF);
    collect_s('{2, 3, 5}, '{-2, -3, -4}, 1'b1);

    // ReLU clamps the negative channel
    s_relu = 1;
    load_s(8'd1, 8'd1, 8'hFF);
    collect_s('{2, 3, 5}, '{0, 0, 0}, 1'b0);
    s_relu = 0;

    // saturation both ways with m0 ~ 1.0
    s_m0 = {2{32'hFFFF_FFFF}};
    load_s(8'd127, 8'd127, 8'h80);
    collect_s('{127, 127, 127}, '{-128, -128, -128}, 1'b0);

    // bias and extra shift n=1: r = floor((acc+2)/4)
    s_m0 = {2{32'h8000_0000}};
    s_n = 8'h11;
    s_bias = {-32'sd3, 32'sd3};
    load_s(8'd1, 8'd1, 8'hFF);
    collect_s('{2, 2, 3}, '{-2, -2, -3}, 1'b0);

    // reset in the middle of the tap scan abandons the frame
    s_n = 8'h00; s_bias = '0;
    load_s(8'd1, 8'd1, 8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_valid", int'(s_vout), 0);
    chk("midrst_in_ready", int'(s_frdy), 1);
    chk("midrst_data", int'(s_dout), 0);
    @(negedge clk); rst_n = 1;
    load_s(8'd1, 8'd1, 8'hFF);
    collect_s('{2, 3, 5}, '{-2, -3, -4}, 1'b0);

    // default shape: every window full, acc 9 -> 5 on all four channels
    d_m0 = {4{32'h8000_0000}};
    for (int t = 0; t < 9; t++) begin
      @(negedge clk); d_wvld = 1; d_waddr = 12'(t); d_wdata = 32'h0101_0101;
    end
    @(negedge clk); d_wvld = 0;
    for (int a = 0; a < 377; a++) begin
      @(negedge clk); d_fvld = 1; d_faddr = 12'(a); d_fdata = 8'd1;
    end
    @(negedge clk); d_fvld = 0;
    for (int k = 0; k < 84; k++) begin
      lat = 0;
      while (!d_vout && lat < 100) begin lat++; @(negedge clk); end
      if (!d_vout) begin chk("dflt_valid_timeout", 0, 1); break; end
      if (k == 0) chk("dflt_latency", lat, 12);
      chk("dflt_addr", int'(d_aout), k);
      chk("dflt_data", int'(d_dout), 32'h0505_0505);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("dflt_done_pulses", d_done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/conv2d_stream_requant.md
Name: conv2d_stream_requant

Overview:
- Parametrised successor of the Conv2D layer engine.
- Buffers one full input feature map, then scans output positions with configurable stride and zero-padding.
- Per output position, accumulates all KERNEL_SIZE²·F_IN_D taps for F_OUT_D output channels in parallel, adds bias, requantises to int8 with optional ReLU, and emits one pixel (all channels) per valid/ready handshake.
- Sits between consecutive layer blocks; defaults reproduce layer 1 (29x13x1 -> 14x6x4).

Parameters:
- F_IN_W, 29, input width.
- F_IN_H, 13, input height.
- F_IN_D, 1, input channels.
- F_OUT_D, 4, output channels.
- KERNEL_SIZE, 3, square kernel side.
- STRIDE, 2, window step in x and y (≥1).
- PAD, 0, zero-pad border width (0..KERNEL_SIZE-1).
- DATA_W, 8, signed feature and weight width.
- ACC_W, 32, signed accumulator and bias width.
- ADDR_W, 12, feature and weight address width.
- Derived, not overridable: F_OUT_W=(F_IN_W+2·PAD-KERNEL_SIZE)/STRIDE+1; F_OUT_H likewise.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- feature_in_valid_i  in  1  input pixel write strobe.
- feature_in_data_i  in  F_IN_D×DATA_W  signed pixel, all input channels.
- feature_in_addr_i  in  ADDR_W  pixel index y·F_IN_W+x.
- feature_in_ready_o  out  1  high while in LOAD.
- kernel_weights_valid_i  in  1  weight write strobe.
- kernel_weights_data_i  in  F_OUT_D×F_IN_D×DATA_W  signed weights for one tap.
- kernel_weights_addr_i  in  ADDR_W  tap index ky·KERNEL_SIZE+kx.
- kernel_biases_data_i  in  F_OUT_D×ACC_W  signed biases.
- kernel_dwscaling_m0_i  in  F_OUT_D×32  unsigned Q0.32 multiplier.
- kernel_dwscaling_n_i  in  F_OUT_D×4  extra right shift.
- relu_en_i  in  1  clamp negatives to 0.
- feature_out_valid_o  out  1  output pixel valid.
- feature_out_data_o  out  F_OUT_D×DATA_W  signed int8 results.
- feature_out_addr_o  out  ADDR_W  oy·F_OUT_W+ox.
- feature_out_ready_i  in  1  downstream accepts.
- frame_done_o  out  1  one-cycle pulse after last output accepted.

Behaviour:
- Reset (async, any state):
  - State goes to LOAD.
  - Counters clear to 0.
  - feature_out_valid_o=0, feature_out_data_o=0, feature_out_addr_o=0, frame_done_o=0, feature_in_ready_o=1.
  - Buffer and weight RAM contents are not cleared.
- FSM: LOAD -> MAC -> QUANT -> OUT -> (MAC | LOAD).
- LOAD:
  - A write is accepted when valid_i and ready_o are both high.
  - Writes with addr ≥ F_IN_W·F_IN_H are ignored.
  - Weight writes are accepted only in LOAD; addr ≥ KERNEL_SIZE² is ignored.
  - Accepting the write to addr F_IN_W·F_IN_H-1 moves to MAC next cycle, with ox=oy=0.
  - Write order is free; the last address is the trigger.
- MAC:
  - Taps iterate ci fastest, then kx, then ky: KERNEL_SIZE²·F_IN_D cycles.
  - Buffer read has 1-cycle latency, so the accumulator pipeline adds 1 cycle.
  - Accumulator is loaded with the bias at tap 0.
  - Input coordinate is ix=ox·STRIDE+kx-PAD (iy likewise). If out of range, the tap contributes 0.
  - Products are DATA_W×DATA_W signed, sign-extended to ACC_W; the sum wraps mod 2^ACC_W (no saturation).
- QUANT (1 cycle, per channel c):
  - p = acc·m0 as a 64-bit signed × unsigned product.
  - r = (p + 2^(31+n)) >>> (32+n), i.e. round-half-up.
  - Saturate r to [-128,127]; if relu_en_i, r=max(r,0).
  - Results are registered into feature_out_data_o; valid_o=1 next cycle.
- OUT:
  - data and addr stay stable while valid=1 and ready=0.
  - On handshake, valid drops the same edge.
  - If not last, advance ox (wrap to 0 and oy++) and go to MAC.
  - If last (ox=F_OUT_W-1, oy=F_OUT_H-1), pulse frame_done_o and go to LOAD.
- Latency: from the last input write to the first valid is KERNEL_SIZE²·F_IN_D+3 cycles. Each later pixel takes the same plus handshake wait.
- Bias, m0, n and relu_en_i must stay stable from entering MAC until frame_done_o. Changing them mid-frame gives undefined values (no X).
- A feature_in_valid_i pulse outside LOAD is ignored; ready_o=0.
- A reset mid-MAC or mid-OUT abandons the frame; a reload is required.

Test Plan:
- F_IN 4x4x1, F_OUT_D=1, K=3, PAD=1, STRIDE=1; all pixels 1, weights 1, bias 0, m0=0x80000000, n=0 -> 16 outputs, addr 0..15; corners 2, edges 3, centre four 5; frame_done_o pulses once.
- Default params: last write, then first feature_out_valid_o after exactly 12 cycles; 84 outputs, addr 0..83, raster order.
- All pixels 127, weights 127, m0=0xFFFFFFFF, n=0 -> 127 on all channels; pixels -128, weights 127 -> -128 (saturation).
- Weights -1, pixels 1, m0=0x80000000, 4x4 PAD=1 -> centre -4 with relu_en_i=0, 0 with relu_en_i=1.
- feature_out_ready_i low for 5 cycles on output 3 -> valid stays 1, data and addr unchanged, no skipped or duplicated addresses; writes during OUT are ignored.
- Reset asserted mid-MAC -> outputs reset immediately, ready_o=1; a reloaded frame yields correct results.
